// File: rtl/commute_pkg.sv
// Shared constants and types for the commute calendar and the downstream bus selector.
package commute_pkg;

   localparam int unsigned HOUR_W        = 5;
   localparam int unsigned DOW_W         = 3;
   localparam int unsigned DOY_W         = 9;
   localparam int unsigned HOURS_PER_DAY = 24;
   localparam int unsigned WEEKDAY_LAST  = 4;

   localparam logic [DOW_W-1:0] DOW_MON = 3'd0;
   localparam logic [DOW_W-1:0] DOW_TUE = 3'd1;
   localparam logic [DOW_W-1:0] DOW_WED = 3'd2;
   localparam logic [DOW_W-1:0] DOW_THU = 3'd3;
   localparam logic [DOW_W-1:0] DOW_FRI = 3'd4;
   localparam logic [DOW_W-1:0] DOW_SAT = 3'd5;
   localparam logic [DOW_W-1:0] DOW_SUN = 3'd6;

   typedef enum logic [1:0] {
      BUS_NONE,
      BUS_GOLD,
      BUS_ORANGE,
      BUS_YELLOW
   } bus_colour_e;

endpackage

// File: rtl/holiday_table.sv
// Programmable holiday register file; flags a match of any valid entry against the current day.
module holiday_table
   import commute_pkg::*;
#(
   parameter int unsigned NUM_HOL       = 8,
   parameter int unsigned DAYS_PER_YEAR = 365,
   localparam int unsigned IDX_W        = $clog2(NUM_HOL)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [DOY_W-1:0] wr_doy,
   input  logic             wr_valid,
   input  logic [DOY_W-1:0] cur_doy,
   output logic             holiday
);

   localparam logic [DOY_W-1:0] DOY_MAX = DOY_W'(DAYS_PER_YEAR - 1);

   logic [NUM_HOL-1:0] valid_q, valid_d;
   logic [DOY_W-1:0]   ent_doy_q [NUM_HOL];
   logic [DOY_W-1:0]   ent_doy_d [NUM_HOL];

   always_comb begin
      valid_d   = valid_q;
      ent_doy_d = ent_doy_q;
      for (int i = 0; i < NUM_HOL; i++) begin
         if (wr_en && (wr_idx == IDX_W'(i))) begin
            valid_d[i]   = wr_valid;
            ent_doy_d[i] = wr_doy;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= '0;
         for (int i = 0; i < NUM_HOL; i++) ent_doy_q[i] <= '0;
      end else begin
         valid_q   <= valid_d;
         ent_doy_q <= ent_doy_d;
      end
   end

   // Out-of-range days are kept in the table but can never match.
   always_comb begin
      holiday = 1'b0;
      for (int i = 0; i < NUM_HOL; i++) begin
         holiday = holiday | (valid_q[i] && (ent_doy_q[i] == cur_doy) &&
                              (ent_doy_q[i] <= DOY_MAX));
      end
   end

endmodule

// File: rtl/commute_calendar.sv
// Hour/day-of-week/day-of-year timekeeper producing the daytime, weekday and holiday flags.
module commute_calendar
   import commute_pkg::*;
#(
   parameter int unsigned DAY_START     = 7,
   parameter int unsigned DAY_END       = 19,
   parameter int unsigned DAYS_PER_YEAR = 365,
   parameter int unsigned NUM_HOL       = 8
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       tick,
   input  logic                       load_en,
   input  logic [4:0]                 load_hour,
   input  logic [2:0]                 load_dow,
   input  logic [8:0]                 load_doy,
   input  logic                       hol_wr_en,
   input  logic [$clog2(NUM_HOL)-1:0] hol_wr_idx,
   input  logic [8:0]                 hol_wr_doy,
   input  logic                       hol_wr_valid,
   output logic [4:0]                 hour,
   output logic [2:0]                 dow,
   output logic [8:0]                 doy,
   output logic                       daytime,
   output logic                       weekday,
   output logic                       holiday,
   output logic                       day_rollover,
   output logic                       load_err
);

   localparam logic [HOUR_W-1:0] HOUR_LAST = HOUR_W'(HOURS_PER_DAY - 1);
   localparam logic [DOY_W-1:0]  DOY_LAST  = DOY_W'(DAYS_PER_YEAR - 1);

   logic [HOUR_W-1:0] hour_q, hour_d;
   logic [DOW_W-1:0]  dow_q, dow_d;
   logic [DOY_W-1:0]  doy_q, doy_d;
   logic              day_rollover_q, day_rollover_d;
   logic              load_err_q, load_err_d;
   logic              load_ok;

   assign load_ok = (load_hour <= HOUR_LAST) && (load_dow <= DOW_SUN) && (load_doy <= DOY_LAST);

   // A load, valid or not, swallows any tick in the same cycle.
   always_comb begin
      hour_d         = hour_q;
      dow_d          = dow_q;
      doy_d          = doy_q;
      day_rollover_d = 1'b0;
      load_err_d     = 1'b0;
      if (load_en) begin
         if (load_ok) begin
            hour_d = load_hour;
            dow_d  = load_dow;
            doy_d  = load_doy;
         end else begin
            load_err_d = 1'b1;
         end
      end else if (tick) begin
         if (hour_q == HOUR_LAST) begin
            hour_d         = '0;
            dow_d          = (dow_q == DOW_SUN) ? DOW_MON : dow_q + 1'b1;
            doy_d          = (doy_q == DOY_LAST) ? '0 : doy_q + 1'b1;
            day_rollover_d = 1'b1;
         end else begin
            hour_d = hour_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hour_q         <= '0;
         dow_q          <= DOW_MON;
         doy_q          <= '0;
         day_rollover_q <= 1'b0;
         load_err_q     <= 1'b0;
      end else begin
         hour_q         <= hour_d;
         dow_q          <= dow_d;
         doy_q          <= doy_d;
         day_rollover_q <= day_rollover_d;
         load_err_q     <= load_err_d;
      end
   end

   holiday_table #(
      .NUM_HOL       (NUM_HOL),
      .DAYS_PER_YEAR (DAYS_PER_YEAR)
   ) u_holiday_table (
      .clock    (clock),
      .reset_n  (reset_n),
      .wr_en    (hol_wr_en),
      .wr_idx   (hol_wr_idx),
      .wr_doy   (hol_wr_doy),
      .wr_valid (hol_wr_valid),
      .cur_doy  (doy_q),
      .holiday  (holiday)
   );

   assign hour         = hour_q;
   assign dow          = dow_q;
   assign doy          = doy_q;
   assign day_rollover = day_rollover_q;
   assign load_err     = load_err_q;
   assign daytime      = (hour_q >= HOUR_W'(DAY_START)) && (hour_q < HOUR_W'(DAY_END));
   assign weekday      = (dow_q <= DOW_W'(WEEKDAY_LAST));

endmodule
